// File: rtl/clock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// clock_mode_ctrl
//
// Top-level mode controller for the 12-hour digital clock. It owns the running
// time-of-day counter and the alarm registers, and shares one external 12-hour
// setter between the time-set and alarm-set requesters. In the edit states,
// button pulses are forwarded to the setter. When the setter raises its
// result-valid level, its result is captured into the selected register set.
//
// Parameters:
//   HOUR_RESET     hour loaded into time and alarm on reset (1..12)
//   ZERO_HOUR_FIX  when 1, a captured setter hour of 0 is stored as 12
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   mode_btn/set_btn/up_btn/down_btn  debounced single-cycle button pulses
//   tick_1hz                     one-cycle pulse once per second
//   set_propagate                setter result-valid level
//   set_is_pm/set_hours/set_minutes  setter result fields
//   setter_set/up/down           registered one-cycle pulses to the setter
//   mode                         00 RUN, 01 TIME_SET, 10 ALARM_SET
//   time_*                       running time of day
//   alarm_*                      stored alarm time, arm flag, sticky ring
// -----------------------------------------------------------------------------
module clock_mode_ctrl #(
   parameter int unsigned HOUR_RESET    = 12,
   parameter bit          ZERO_HOUR_FIX = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode_btn,
   input  logic       set_btn,
   input  logic       up_btn,
   input  logic       down_btn,
   input  logic       tick_1hz,
   input  logic       set_propagate,
   input  logic       set_is_pm,
   input  logic [3:0] set_hours,
   input  logic [5:0] set_minutes,
   output logic       setter_set,
   output logic       setter_up,
   output logic       setter_down,
   output logic [1:0] mode,
   output logic       time_is_pm,
   output logic [3:0] time_hours,
   output logic [5:0] time_minutes,
   output logic [5:0] time_seconds,
   output logic       alarm_is_pm,
   output logic [3:0] alarm_hours,
   output logic [5:0] alarm_minutes,
   output logic       alarm_enable,
   output logic       alarm_ring
);

   localparam logic [3:0] HOUR_INIT = 4'(HOUR_RESET);

   typedef enum logic [2:0] {
      S_RUN,
      S_T_ENTRY,
      S_T_EDIT,
      S_A_ENTRY,
      S_A_EDIT
   } state_t;

   state_t     state;
   state_t     state_next;

   logic       prop_d;
   logic       prop_rise;
   logic       tick_d;

   logic       setter_set_next;
   logic       setter_up_next;
   logic       setter_down_next;

   logic       capture_time;
   logic       capture_alarm;
   logic       toggle_enable;
   logic       clear_request;

   logic [3:0] captured_hours;

   logic       inc_is_pm;
   logic [3:0] inc_hours;
   logic [5:0] inc_minutes;
   logic [5:0] inc_seconds;

   logic       alarm_match;
   logic       ring_clear;

   // The setter signals a finished edit by raising set_propagate; only the
   // rising edge counts as a fresh result.
   assign prop_rise = set_propagate & ~prop_d;

   // A setter hour of 0 is not a legal 12-hour value, so it is mapped to 12.
   assign captured_hours = (ZERO_HOUR_FIX && (set_hours == 4'd0)) ? 4'd12 : set_hours;

   // The alarm fires only on the exact second the minute begins.
   assign alarm_match = (time_seconds == 6'd0) &&
                        (time_is_pm == alarm_is_pm) &&
                        (time_hours == alarm_hours) &&
                        (time_minutes == alarm_minutes);

   // Disarming the alarm silences it as well. A clear always beats a new ring
   // in the same cycle.
   assign ring_clear = clear_request | (toggle_enable & alarm_enable);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state, button routing and mode decode. In RUN, only the
   // highest-priority button acts. The entry states last exactly one cycle. In
   // that cycle the setter is kicked with a set pulse only if it reports idle,
   // which keeps it in step after a reset that did not reach the setter. In
   // the edit states mode_btn is deliberately ignored, so an edit cannot be
   // aborted half way and leave the setter out of step.
   always_comb begin
      state_next       = state;
      setter_set_next  = 1'b0;
      setter_up_next   = 1'b0;
      setter_down_next = 1'b0;
      capture_time     = 1'b0;
      capture_alarm    = 1'b0;
      toggle_enable    = 1'b0;
      clear_request    = 1'b0;
      mode             = 2'b00;
      case (state)
         S_RUN: begin
            if (mode_btn) begin
               state_next = S_T_ENTRY;
            end else if (set_btn) begin
               state_next = S_A_ENTRY;
            end else if (up_btn) begin
               toggle_enable = 1'b1;
            end else if (down_btn) begin
               clear_request = 1'b1;
            end
         end
         S_T_ENTRY: begin
            mode            = 2'b01;
            setter_set_next = set_propagate;
            state_next      = S_T_EDIT;
         end
         S_T_EDIT: begin
            mode             = 2'b01;
            setter_set_next  = set_btn;
            setter_up_next   = ~set_btn & up_btn;
            setter_down_next = ~set_btn & ~up_btn & down_btn;
            if (prop_rise) begin
               capture_time = 1'b1;
               state_next   = S_RUN;
            end
         end
         S_A_ENTRY: begin
            mode            = 2'b10;
            setter_set_next = set_propagate;
            state_next      = S_A_EDIT;
         end
         S_A_EDIT: begin
            mode             = 2'b10;
            setter_set_next  = set_btn;
            setter_up_next   = ~set_btn & up_btn;
            setter_down_next = ~set_btn & ~up_btn & down_btn;
            if (prop_rise) begin
               capture_alarm = 1'b1;
               state_next    = S_RUN;
            end
         end
         default: begin
            state_next = S_RUN;
         end
      endcase
   end

   // One-second increment of the running time with 12-hour rollover. Going
   // from 11 to 12 flips AM/PM; going from 12 to 1 does not.
   always_comb begin
      inc_is_pm   = time_is_pm;
      inc_hours   = time_hours;
      inc_minutes = time_minutes;
      inc_seconds = time_seconds + 6'd1;
      if (time_seconds == 6'd59) begin
         inc_seconds = 6'd0;
         inc_minutes = time_minutes + 6'd1;
         if (time_minutes == 6'd59) begin
            inc_minutes = 6'd0;
            if (time_hours == 4'd11) begin
               inc_hours = 4'd12;
               inc_is_pm = ~time_is_pm;
            end else if (time_hours == 4'd12) begin
               inc_hours = 4'd1;
            end else begin
               inc_hours = time_hours + 4'd1;
            end
         end
      end
   end

   // Edge-detect and delay registers plus the registered setter pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         prop_d      <= 1'b0;
         tick_d      <= 1'b0;
         setter_set  <= 1'b0;
         setter_up   <= 1'b0;
         setter_down <= 1'b0;
      end else begin
         prop_d      <= set_propagate;
         tick_d      <= tick_1hz;
         setter_set  <= setter_set_next;
         setter_up   <= setter_up_next;
         setter_down <= setter_down_next;
      end
   end

   // Running time of day. A time capture takes precedence over a coincident
   // tick: the captured value starts at second 0 and that tick is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         time_is_pm   <= 1'b0;
         time_hours   <= HOUR_INIT;
         time_minutes <= 6'd0;
         time_seconds <= 6'd0;
      end else if (capture_time) begin
         time_is_pm   <= set_is_pm;
         time_hours   <= captured_hours;
         time_minutes <= set_minutes;
         time_seconds <= 6'd0;
      end else if (tick_1hz) begin
         time_is_pm   <= inc_is_pm;
         time_hours   <= inc_hours;
         time_minutes <= inc_minutes;
         time_seconds <= inc_seconds;
      end
   end

   // Alarm registers, arm flag and sticky ring. The ring compare runs one
   // cycle after the tick, so it sees the time value that the tick produced.
   always_ff @(posedge clk) begin
      if (reset) begin
         alarm_is_pm   <= 1'b0;
         alarm_hours   <= HOUR_INIT;
         alarm_minutes <= 6'd0;
         alarm_enable  <= 1'b0;
         alarm_ring    <= 1'b0;
      end else begin
         if (capture_alarm) begin
            alarm_is_pm   <= set_is_pm;
            alarm_hours   <= captured_hours;
            alarm_minutes <= set_minutes;
         end
         if (toggle_enable) begin
            alarm_enable <= ~alarm_enable;
         end
         if (ring_clear) begin
            alarm_ring <= 1'b0;
         end else if (tick_d && alarm_enable && alarm_match) begin
            alarm_ring <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_mode_ctrl
//
// Directed self-checking bench for clock_mode_ctrl. The bench drives inputs
// one time unit after each rising edge and samples outputs at that same point,
// after the registers have settled. All expected values are worked out by hand
// from the clock behaviour.
// -----------------------------------------------------------------------------
module tb_clock_mode_ctrl;

   logic       clk;
   logic       reset;
   logic       mode_btn;
   logic       set_btn;
   logic       up_btn;
   logic       down_btn;
   logic       tick_1hz;
   logic       set_propagate;
   logic       set_is_pm;
   logic [3:0] set_hours;
   logic [5:0] set_minutes;
   logic       setter_set;
   logic       setter_up;
   logic       setter_down;
   logic [1:0] mode;
   logic       time_is_pm;
   logic [3:0] time_hours;
   logic [5:0] time_minutes;
   logic [5:0] time_seconds;
   logic       alarm_is_pm;
   logic [3:0] alarm_hours;
   logic [5:0] alarm_minutes;
   logic       alarm_enable;
   logic       alarm_ring;

   int total;
   int bad;

   clock_mode_ctrl #(
      .HOUR_RESET   (12),
      .ZERO_HOUR_FIX(1'b1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .mode_btn     (mode_btn),
      .set_btn      (set_btn),
      .up_btn       (up_btn),
      .down_btn     (down_btn),
      .tick_1hz     (tick_1hz),
      .set_propagate(set_propagate),
      .set_is_pm    (set_is_pm),
      .set_hours    (set_hours),
      .set_minutes  (set_minutes),
      .setter_set   (setter_set),
      .setter_up    (setter_up),
      .setter_down  (setter_down),
      .mode         (mode),
      .time_is_pm   (time_is_pm),
      .time_hours   (time_hours),
      .time_minutes (time_minutes),
      .time_seconds (time_seconds),
      .alarm_is_pm  (alarm_is_pm),
      .alarm_hours  (alarm_hours),
      .alarm_minutes(alarm_minutes),
      .alarm_enable (alarm_enable),
      .alarm_ring   (alarm_ring)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and settle just past the edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Pulse the four buttons for exactly one cycle.
   task automatic applyStimulus(input logic m, input logic s, input logic u, input logic d);
      mode_btn = m;
      set_btn  = s;
      up_btn   = u;
      down_btn = d;
      cycle();
      mode_btn = 1'b0;
      set_btn  = 1'b0;
      up_btn   = 1'b0;
      down_btn = 1'b0;
   endtask

   // Count one comparison and report it if it does not hold.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drive the setter result lines.
   task automatic setterResult(input logic pm, input logic [3:0] hr, input logic [5:0] mn);
      set_is_pm     = pm;
      set_hours     = hr;
      set_minutes   = mn;
      set_propagate = 1'b1;
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      reset         = 1'b1;
      mode_btn      = 1'b0;
      set_btn       = 1'b0;
      up_btn        = 1'b0;
      down_btn      = 1'b0;
      tick_1hz      = 1'b0;
      set_propagate = 1'b1;
      set_is_pm     = 1'b0;
      set_hours     = 4'd0;
      set_minutes   = 6'd0;

      $display("[TB] reset");
      cycle();
      cycle();
      reset = 1'b0;
      checkOutput("rst_mode", 32'(mode), 32'd0);
      checkOutput("rst_time_hours", 32'(time_hours), 32'd12);
      checkOutput("rst_time_pm", 32'(time_is_pm), 32'd0);
      checkOutput("rst_time_min", 32'(time_minutes), 32'd0);
      checkOutput("rst_alarm_hours", 32'(alarm_hours), 32'd12);
      checkOutput("rst_alarm_enable", 32'(alarm_enable), 32'd0);
      checkOutput("rst_alarm_ring", 32'(alarm_ring), 32'd0);
      checkOutput("rst_setter", 32'({setter_set, setter_up, setter_down}), 32'd0);

      $display("[TB] timekeeping");
      tick_1hz = 1'b1;
      repeat (3600) cycle();
      checkOutput("t1h_hours", 32'(time_hours), 32'd1);
      checkOutput("t1h_min_sec", 32'({time_minutes, time_seconds}), 32'd0);
      checkOutput("t1h_pm", 32'(time_is_pm), 32'd0);
      repeat (39599) cycle();
      checkOutput("t1159_hours", 32'(time_hours), 32'd11);
      checkOutput("t1159_sec", 32'(time_seconds), 32'd59);
      checkOutput("t1159_pm", 32'(time_is_pm), 32'd0);
      cycle();
      checkOutput("noon_hours", 32'(time_hours), 32'd12);
      checkOutput("noon_pm", 32'(time_is_pm), 32'd1);
      checkOutput("noon_min_sec", 32'({time_minutes, time_seconds}), 32'd0);
      repeat (3600) cycle();
      tick_1hz = 1'b0;
      checkOutput("pm1_hours", 32'(time_hours), 32'd1);
      checkOutput("pm1_pm", 32'(time_is_pm), 32'd1);

      $display("[TB] time set entry and forwarding");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("tentry_mode", 32'(mode), 32'd1);
      checkOutput("tentry_set_early", 32'(setter_set), 32'd0);
      cycle();
      checkOutput("tentry_set_pulse", 32'(setter_set), 32'd1);
      set_propagate = 1'b0;
      cycle();
      checkOutput("tentry_set_end", 32'(setter_set), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("fwd_up", 32'(setter_up), 32'd1);
      checkOutput("fwd_down", 32'(setter_down), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("tedit_mode_ignored", 32'(mode), 32'd1);
      checkOutput("tedit_up_done", 32'(setter_up), 32'd0);

      $display("[TB] time capture");
      setterResult(1'b1, 4'd7, 6'd30);
      cycle();
      checkOutput("cap_hours", 32'(time_hours), 32'd7);
      checkOutput("cap_min", 32'(time_minutes), 32'd30);
      checkOutput("cap_pm", 32'(time_is_pm), 32'd1);
      checkOutput("cap_mode", 32'(mode), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      set_propagate = 1'b0;
      cycle();
      setterResult(1'b0, 4'd0, 6'd15);
      cycle();
      checkOutput("cap0_hours", 32'(time_hours), 32'd12);
      checkOutput("cap0_min", 32'(time_minutes), 32'd15);
      checkOutput("cap0_pm", 32'(time_is_pm), 32'd0);

      $display("[TB] alarm set");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("aentry_mode", 32'(mode), 32'd2);
      cycle();
      checkOutput("aentry_set_pulse", 32'(setter_set), 32'd1);
      set_propagate = 1'b0;
      cycle();
      setterResult(1'b0, 4'd6, 6'd0);
      cycle();
      checkOutput("acap_hours", 32'(alarm_hours), 32'd6);
      checkOutput("acap_min", 32'(alarm_minutes), 32'd0);
      checkOutput("acap_mode", 32'(mode), 32'd0);
      checkOutput("acap_time_kept", 32'(time_minutes), 32'd15);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("arm", 32'(alarm_enable), 32'd1);

      $display("[TB] alarm ring");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      set_propagate = 1'b0;
      cycle();
      setterResult(1'b0, 4'd5, 6'd59);
      cycle();
      tick_1hz = 1'b1;
      repeat (59) cycle();
      tick_1hz = 1'b0;
      checkOutput("pre_alarm_sec", 32'(time_seconds), 32'd59);
      checkOutput("pre_alarm_ring", 32'(alarm_ring), 32'd0);
      tick_1hz = 1'b1;
      cycle();
      tick_1hz = 1'b0;
      checkOutput("alarm_time_hours", 32'(time_hours), 32'd6);
      checkOutput("ring_not_yet", 32'(alarm_ring), 32'd0);
      cycle();
      checkOutput("ring_set", 32'(alarm_ring), 32'd1);
      repeat (3) cycle();
      checkOutput("ring_sticky", 32'(alarm_ring), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("ring_cleared", 32'(alarm_ring), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("disarm", 32'(alarm_enable), 32'd0);

      $display("[TB] capture beats tick");
      tick_1hz = 1'b1;
      repeat (5) cycle();
      tick_1hz = 1'b0;
      checkOutput("pre_cap_sec", 32'(time_seconds), 32'd5);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      set_propagate = 1'b0;
      cycle();
      setterResult(1'b1, 4'd3, 6'd45);
      tick_1hz = 1'b1;
      cycle();
      tick_1hz = 1'b0;
      checkOutput("cwin_sec", 32'(time_seconds), 32'd0);
      checkOutput("cwin_min", 32'(time_minutes), 32'd45);
      checkOutput("cwin_hours", 32'(time_hours), 32'd3);
      checkOutput("cwin_pm", 32'(time_is_pm), 32'd1);

      $display("[TB] propagate edge in RUN");
      set_propagate = 1'b0;
      cycle();
      setterResult(1'b0, 4'd9, 6'd9);
      cycle();
      checkOutput("run_prop_time", 32'(time_hours), 32'd3);
      checkOutput("run_prop_alarm", 32'(alarm_hours), 32'd6);
      checkOutput("run_prop_mode", 32'(mode), 32'd0);

      $display("[TB] reset in alarm edit");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      cycle();
      set_propagate = 1'b0;
      reset         = 1'b1;
      up_btn        = 1'b1;
      cycle();
      reset  = 1'b0;
      up_btn = 1'b0;
      checkOutput("mrst_mode", 32'(mode), 32'd0);
      checkOutput("mrst_alarm_hours", 32'(alarm_hours), 32'd12);
      checkOutput("mrst_alarm_min", 32'(alarm_minutes), 32'd0);
      checkOutput("mrst_setter", 32'({setter_set, setter_up, setter_down}), 32'd0);
      checkOutput("mrst_time_hours", 32'(time_hours), 32'd12);

      $display("[TB] resync entry with busy setter");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("resync_mode", 32'(mode), 32'd1);
      cycle();
      checkOutput("resync_no_set", 32'(setter_set), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Top-level mode controller for the 12-hour digital clock.
- Owns the running time-of-day counter and the alarm registers.
- Shares one 12-hour setter instance between the time-set and alarm-set requesters: it routes button pulses to the setter and captures the setter's result into the selected register set.
- Drives the display-mode select and the alarm ring output.

Parameters:
- HOUR_RESET, 12, hour loaded into time and alarm on reset (1..12).
- ZERO_HOUR_FIX, 1, when 1 a captured setter hour of 0 is stored as 12.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mode_btn  in  1  debounced single-cycle pulse
- set_btn  in  1  debounced single-cycle pulse
- up_btn  in  1  debounced single-cycle pulse
- down_btn  in  1  debounced single-cycle pulse
- tick_1hz  in  1  single-cycle pulse, once per second
- set_propagate  in  1  setter result-valid level
- set_is_pm  in  1  setter AM/PM field
- set_hours  in  4  setter hour field
- set_minutes  in  6  setter minute field
- setter_set  out  1  pulse to setter set input
- setter_up  out  1  pulse to setter up input
- setter_down  out  1  pulse to setter down input
- mode  out  2  00 RUN, 01 TIME_SET, 10 ALARM_SET
- time_is_pm  out  1  running time AM/PM
- time_hours  out  4  running time hour, 1..12
- time_minutes  out  6  running time minute, 0..59
- time_seconds  out  6  running time second, 0..59
- alarm_is_pm  out  1  stored alarm AM/PM
- alarm_hours  out  4  stored alarm hour, 1..12
- alarm_minutes  out  6  stored alarm minute, 0..59
- alarm_enable  out  1  alarm armed
- alarm_ring  out  1  alarm sounding (sticky)

Behaviour:
- Reset values:
  - time = 12:00:00 AM (is_pm 0, hours HOUR_RESET, minutes 0, seconds 0).
  - alarm = 12:00 AM; alarm_enable 0; alarm_ring 0.
  - setter_* 0; FSM in RUN; mode 00; prop_d 0.
- Propagate edge detect: prop_d registers set_propagate; prop_rise = set_propagate & ~prop_d.
- FSM states: RUN, T_ENTRY, T_EDIT, A_ENTRY, A_EDIT. mode = 01 in T_*, 10 in A_*, 00 in RUN.
- RUN, button priority mode > set > up > down (only the highest-priority button acts):
  - mode_btn -> T_ENTRY.
  - set_btn -> A_ENTRY.
  - up_btn toggles alarm_enable.
  - down_btn clears alarm_ring.
- T_ENTRY / A_ENTRY: one cycle only.
  - If set_propagate=1 (setter idle), setter_set=1 on the next cycle. This moves the setter to its first edit field with fields cleared.
  - If set_propagate=0 (setter already editing after power-up), no pulse is issued.
  - All buttons are ignored in the entry cycle.
  - Then go to T_EDIT / A_EDIT.
- T_EDIT / A_EDIT:
  - Priority set > up > down; only the highest button is forwarded as setter_set, setter_up or setter_down, registered with 1-cycle latency, 1 cycle wide.
  - mode_btn is ignored, so there is no abort and the setter never desyncs.
- Capture, on prop_rise in T_EDIT / A_EDIT:
  - At the next edge, the target registers load set_is_pm, set_hours (0 becomes 12 if ZERO_HOUR_FIX) and set_minutes.
  - T_EDIT also zeroes time_seconds.
  - FSM returns to RUN on the same edge.
  - prop_rise outside the *_EDIT states is ignored.
- Timekeeping, on tick_1hz in every state:
  - seconds 59 -> 0 with minute carry.
  - minutes 59 -> 0 with hour carry.
  - hours 11 -> 12 toggles is_pm.
  - hours 12 -> 1 leaves is_pm unchanged.
  - If tick coincides with a T_EDIT capture, the capture wins: the captured value is loaded with seconds 0 and the tick is dropped.
- Alarm:
  - tick_d is tick_1hz delayed one cycle.
  - On tick_d, if alarm_enable=1 and time_seconds=0 and {is_pm,hours,minutes} equals the alarm, alarm_ring <= 1.
  - alarm_ring is sticky. It clears on RUN down_btn or when alarm_enable goes to 0.
  - If clear and set occur in the same cycle, clear wins.
  - A capture into the alarm registers does not affect alarm_ring.
- Reset mid-operation (e.g. in T_EDIT): all registers return to reset values. The setter is not reset. The next entry uses the set_propagate rule above to resync.

Test Plan:
- Reset, then 3600 tick_1hz pulses -> time 01:00:00 AM. Continue from 11:59:59 AM plus one tick -> 12:00:00 PM with time_is_pm 1.
- RUN mode_btn with set_propagate=1 -> T_ENTRY; mode=01; one setter_set pulse 2 cycles after mode_btn. Then up_btn and down_btn in the same cycle -> only setter_up.
- In T_EDIT, drive set_propagate 0->1 with set_hours=7, set_minutes=30, set_is_pm=1 -> next edge time 07:30:00 PM, mode 00. Repeat with set_hours=0 -> time_hours 12.
- RUN set_btn, then capture 06:00 AM -> alarm set, time unchanged. up_btn -> alarm_enable 1. Time reaches 06:00:00 AM -> alarm_ring 1 two cycles after tick. down_btn -> alarm_ring 0.
- tick_1hz coincident with prop_rise in T_EDIT -> time_seconds 0, captured value exact. mode_btn during T_EDIT -> ignored, mode stays 01.
- reset asserted in A_EDIT -> next edge mode 00, alarm 12:00 AM, setter_* 0.
